// File: rtl/conv_layer_scheduler_pkg.sv
// conv_layer_scheduler_pkg: shared state encoding and frame-geometry helpers
package conv_layer_scheduler_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CLR, S_ISSUE, S_DRAIN, S_DONE} state_t;
  function automatic int in_pix(input int img);
    return img * img;
  endfunction
  function automatic int out_pix(input int img);
    return (img - 2) * (img - 2);
  endfunction
  function automatic int cw(input int n);
    return n < 2 ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/conv_layer_scheduler_if.sv
// conv_layer_scheduler_if: control, input-buffer, engine and writer signals of the scheduler
interface conv_layer_scheduler_if #(
  parameter int AW = 14,
  parameter int FW = 4,
  parameter int WW = 18
);
  logic start;
  logic abort;
  logic out_ready;
  logic eng_valid_out;
  logic rd_en;
  logic [AW-1:0] rd_addr;
  logic eng_valid_in;
  logic eng_clr;
  logic [FW-1:0] fmap_idx;
  logic wr_en;
  logic [WW-1:0] wr_addr;
  logic busy;
  logic done;
  logic err;
  modport master (
    output start, abort, out_ready, eng_valid_out,
    input rd_en, rd_addr, eng_valid_in, eng_clr, fmap_idx, wr_en, wr_addr, busy, done, err
  );
  modport slave (
    input start, abort, out_ready, eng_valid_out,
    output rd_en, rd_addr, eng_valid_in, eng_clr, fmap_idx, wr_en, wr_addr, busy, done, err
  );
endinterface

// File: rtl/conv_layer_scheduler_pixel_addr_counter.sv
// pixel_addr_counter: wrapping 0..N-1 counter with enable, clear and last-value flag
module pixel_addr_counter #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt,
  output logic         o_last
);
  logic [W-1:0] r_cnt;
  assign o_cnt = r_cnt;
  assign o_last = r_cnt == W'(N - 1);
  // clear wins over enable; enabling on the last value wraps to zero
  always_ff @(posedge clk)
    r_cnt <= (rst || i_clr) ? '0 : !i_en ? r_cnt : o_last ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/conv_layer_scheduler.sv
// conv_layer_scheduler: runs one shared 3x3 engine over NUM_FMAPS passes of a full input frame
module conv_layer_scheduler
  import conv_layer_scheduler_pkg::*;
#(
  parameter int IMG_SIZE = 104,
  parameter int NUM_FMAPS = 16,
  parameter int RD_LAT = 1
) (
  input logic clk,
  input logic rst,
  conv_layer_scheduler_if.slave bus
);
  localparam int IN_PIX = in_pix(IMG_SIZE);
  localparam int OUT_PIX = out_pix(IMG_SIZE);
  localparam int AW = cw(IN_PIX);
  localparam int FW = cw(NUM_FMAPS);
  localparam int WW = cw(NUM_FMAPS * OUT_PIX);
  localparam int CW = cw(OUT_PIX + 1);
  state_t r_state;
  logic [FW-1:0] r_fmap;
  logic [RD_LAT-1:0] r_vld;
  logic r_clr;
  logic r_err;
  logic [AW-1:0] w_rd_addr;
  logic [CW-1:0] w_out_cnt;
  logic w_rd_last;
  logic w_out_full;
  logic w_abort;
  logic w_go;
  logic w_act;
  logic w_pass_done;
  logic w_last_fmap;
  assign w_abort = bus.abort && r_state != S_IDLE;
  assign w_go = r_state == S_IDLE && bus.start && !bus.abort;
  assign w_act = r_state == S_ISSUE || r_state == S_DRAIN;
  assign w_pass_done = r_state == S_DRAIN && w_out_full;
  assign w_last_fmap = r_fmap == FW'(NUM_FMAPS - 1);
  assign bus.rd_en = r_state == S_ISSUE && bus.out_ready && !bus.abort;
  assign bus.rd_addr = w_rd_addr;
  assign bus.eng_valid_in = r_vld[RD_LAT-1];
  assign bus.eng_clr = r_clr;
  assign bus.fmap_idx = r_fmap;
  assign bus.wr_en = bus.eng_valid_out && w_act && !w_out_full;
  assign bus.wr_addr = WW'(r_fmap) * WW'(OUT_PIX) + WW'(w_out_cnt);
  assign bus.busy = r_state != S_IDLE;
  assign bus.done = r_state == S_DONE;
  assign bus.err = r_err;
  pixel_addr_counter #(.N(IN_PIX), .W(AW)) u_rd_cnt (
    .clk(clk),
    .rst(rst),
    .i_en(bus.rd_en),
    .i_clr(w_abort),
    .o_cnt(w_rd_addr),
    .o_last(w_rd_last)
  );
  // counts 0..OUT_PIX so "full" is the last value and the counter never wraps mid-pass
  pixel_addr_counter #(.N(OUT_PIX + 1), .W(CW)) u_out_cnt (
    .clk(clk),
    .rst(rst),
    .i_en(bus.wr_en),
    .i_clr(w_abort || w_pass_done),
    .o_cnt(w_out_cnt),
    .o_last(w_out_full)
  );
  // pass sequencing, weight-set select, engine clear strobe, read-valid delay line and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_fmap <= '0;
      r_vld <= '0;
      r_clr <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_vld <= w_abort ? '0 : RD_LAT'({r_vld, bus.rd_en});
      r_clr <= w_abort || w_go || (w_pass_done && !w_last_fmap);
      r_err <= r_err || (bus.eng_valid_out && !bus.wr_en);
      if (w_abort) begin
        r_state <= S_IDLE;
        r_fmap <= '0;
      end else begin
        case (r_state)
          S_IDLE: r_state <= w_go ? S_CLR : S_IDLE;
          S_CLR: r_state <= S_ISSUE;
          S_ISSUE: r_state <= (bus.rd_en && w_rd_last) ? S_DRAIN : S_ISSUE;
          S_DRAIN: begin
            r_state <= !w_out_full ? S_DRAIN : w_last_fmap ? S_DONE : S_CLR;
            r_fmap <= (w_out_full && !w_last_fmap) ? r_fmap + 1'b1 : r_fmap;
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_fmap <= '0;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end
endmodule
